// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-sequencing controller.
package router_pkg;

  localparam int PORTS_DEF   = 3;
  localparam int TIMEOUT_DEF = 30;
  localparam int TMR_W       = 5;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  typedef struct packed {
    logic lfd;
    logic ld;
    logic laf;
    logic detect_add;
    logic rst_int_reg;
    logic busy;
  } strobes_t;

  function automatic strobes_t decode_state(state_t s);
    strobes_t o;
    o = '0;
    case (s)
      DECODE_ADDRESS:     o.detect_add  = 1'b1;
      LOAD_FIRST_DATA:    begin o.lfd = 1'b1; o.busy = 1'b1; end
      LOAD_DATA:          o.ld = 1'b1;
      FIFO_FULL_STATE:    o.busy = 1'b1;
      LOAD_AFTER_FULL:    begin o.laf = 1'b1; o.busy = 1'b1; end
      LOAD_PARITY:        o.busy = 1'b1;
      CHECK_PARITY_ERROR: begin o.rst_int_reg = 1'b1; o.busy = 1'b1; end
      WAIT_TILL_EMPTY:    o.busy = 1'b1;
      default:            o = '0;
    endcase
    return o;
  endfunction

  // States in which the selected FIFO takes a byte.
  function automatic logic is_write(state_t s);
    return (s == LOAD_FIRST_DATA) || (s == LOAD_DATA) ||
           (s == LOAD_AFTER_FULL) || (s == LOAD_PARITY);
  endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Bundle of the source, register-block and FIFO signals around the router FSM.
interface router_fsm_if
  import router_pkg::*;
#(
  parameter int PORTS = PORTS_DEF
);
  logic             pkt_valid;
  logic [1:0]       addr;
  logic             parity_done;
  logic             low_pkt_valid;
  logic [PORTS-1:0] fifo_full;
  logic [PORTS-1:0] fifo_empty;
  logic [PORTS-1:0] rd_en;
  logic [PORTS-1:0] wr_en;
  logic             lfd_state;
  logic             ld_state;
  logic             laf_state;
  logic             detect_add;
  logic             rst_int_reg;
  logic             busy;
  logic [PORTS-1:0] vld_out;
  logic [PORTS-1:0] soft_rst;

  modport master (
    output pkt_valid, addr, parity_done, low_pkt_valid, fifo_full, fifo_empty, rd_en,
    input  wr_en, lfd_state, ld_state, laf_state, detect_add, rst_int_reg, busy,
           vld_out, soft_rst
  );

  modport slave (
    input  pkt_valid, addr, parity_done, low_pkt_valid, fifo_full, fifo_empty, rd_en,
    output wr_en, lfd_state, ld_state, laf_state, detect_add, rst_int_reg, busy,
           vld_out, soft_rst
  );
endinterface

// File: rtl/router_sync_timer.sv
// One port's unread-data watchdog: pulses soft_rst_o after TIMEOUT unread cycles.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic vld_i,
  input  logic rd_en_i,
  input  logic empty_i,
  output logic soft_rst_o
);
  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             soft_rst_q, soft_rst_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d      = cnt_q;
    soft_rst_d = 1'b0;
    if (rd_en_i || empty_i) begin
      cnt_d = '0;
    end else if (vld_i) begin
      if (cnt_q == LAST) begin
        cnt_d      = '0;
        soft_rst_d = 1'b1;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      soft_rst_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      soft_rst_q <= soft_rst_d;
    end
  end

  assign soft_rst_o = soft_rst_q;

endmodule

// File: rtl/router_fsm.sv
// Packet-sequencing controller: header decode, FIFO write enables, stall and soft reset.
module router_fsm
  import router_pkg::*;
#(
  parameter int PORTS   = PORTS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic        clk,
  input logic        rst,
  router_fsm_if.slave bus
);
  state_t           state_q, state_d;
  logic [1:0]       addr_q, addr_d;
  strobes_t         strb_q;
  logic [PORTS-1:0] wr_en_q;
  logic [PORTS-1:0] soft_rst;
  logic             addr_ok;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    addr_ok = (bus.addr != ADDR_INVALID) && (int'(bus.addr) < PORTS);
    case (state_q)
      DECODE_ADDRESS:
        if (bus.pkt_valid && addr_ok) begin
          addr_d  = bus.addr;
          state_d = bus.fifo_empty[bus.addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      WAIT_TILL_EMPTY:
        if (bus.fifo_empty[addr_q]) state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:
        state_d = LOAD_DATA;
      LOAD_DATA:
        if (bus.fifo_full[addr_q])  state_d = FIFO_FULL_STATE;
        else if (!bus.pkt_valid)    state_d = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!bus.fifo_full[addr_q]) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (bus.parity_done)        state_d = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
        else                        state_d = LOAD_DATA;
      LOAD_PARITY:
        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        state_d = bus.fifo_full[addr_q] ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:
        state_d = DECODE_ADDRESS;
    endcase
    // A timed-out destination abandons the packet in flight.
    if (state_q != DECODE_ADDRESS && soft_rst[addr_q]) state_d = DECODE_ADDRESS;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
      strb_q  <= decode_state(DECODE_ADDRESS);
      wr_en_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      strb_q  <= decode_state(state_d);
      wr_en_q <= is_write(state_d) ? (PORTS'(1) << addr_d) : '0;
    end
  end

  for (genvar i = 0; i < PORTS; i++) begin : g_tmr
    router_sync_timer #(.TIMEOUT(TIMEOUT)) u_tmr (
      .clk        (clk),
      .rst        (rst),
      .vld_i      (~bus.fifo_empty[i]),
      .rd_en_i    (bus.rd_en[i]),
      .empty_i    (bus.fifo_empty[i]),
      .soft_rst_o (soft_rst[i])
    );
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.lfd_state   = strb_q.lfd;
  assign bus.ld_state    = strb_q.ld;
  assign bus.laf_state   = strb_q.laf;
  assign bus.detect_add  = strb_q.detect_add;
  assign bus.rst_int_reg = strb_q.rst_int_reg;
  assign bus.busy        = strb_q.busy;
  assign bus.vld_out     = ~bus.fifo_empty;
  assign bus.soft_rst    = soft_rst;

endmodule

// File: doc/router_fsm.md
# router_fsm

Packet-sequencing controller for the 1x3 router. It decodes the header address of an incoming packet and drives the per-port write enables and the `lfd_state` qualifier into the three `router_fifo` instances. It stalls the source while the target FIFO is full or still draining a previous packet, and it generates each FIFO's `soft_rst` when a destination stops reading for too long.

## Interface
- `PORTS`, 3: number of output FIFOs; the address space is `0..PORTS-1`.
- `TIMEOUT`, 30: consecutive unread cycles before a port's soft reset fires.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `pkt_valid` in 1: source has a valid byte on the bus.
- `addr` in 2: header destination, `data_in[1:0]`; sampled only in DECODE_ADDRESS.
- `parity_done` in 1: register block has captured the parity byte.
- `low_pkt_valid` in 1: register block saw `pkt_valid` fall while the FIFO was full.
- `fifo_full` in PORTS: per-FIFO `full`.
- `fifo_empty` in PORTS: per-FIFO `empty`.
- `rd_en` in PORTS: destination read enables.
- `wr_en` out PORTS: one-hot write enable to `fifo[addr_q]`.
- `lfd_state` out 1: header-load qualifier, shared by all FIFOs.
- `ld_state`, `laf_state`, `detect_add`, `rst_int_reg` out 1 each: state strobes to the register block.
- `busy` out 1: source must hold its data.
- `vld_out` out PORTS: `~fifo_empty`.
- `soft_rst` out PORTS: one-cycle per-FIFO soft reset.

## Operation
- `addr_q` is a 2-bit register, loaded in DECODE_ADDRESS when a valid address is accepted.
- Moore outputs, decoded from the state register:
  - DECODE_ADDRESS: `detect_add`=1.
  - LOAD_FIRST_DATA: `lfd_state`=1, `busy`=1, write.
  - LOAD_DATA: `ld_state`=1, `busy`=0, write.
  - FIFO_FULL_STATE: `busy`=1, no write.
  - LOAD_AFTER_FULL: `laf_state`=1, `busy`=1, write.
  - LOAD_PARITY: `busy`=1, write.
  - CHECK_PARITY_ERROR: `rst_int_reg`=1, `busy`=1.
  - WAIT_TILL_EMPTY: `busy`=1.
- "Write" means `wr_en[addr_q]`=1; all other `wr_en` bits are 0.
- Transitions:
  - DECODE_ADDRESS:
    - `pkt_valid` and `addr`<PORTS and `fifo_empty[addr]` → LOAD_FIRST_DATA.
    - `pkt_valid` and `addr`<PORTS and not empty → WAIT_TILL_EMPTY.
    - `addr`==3 → stay; the packet is dropped and `addr_q` is unchanged.
  - WAIT_TILL_EMPTY: on `fifo_empty[addr_q]` → LOAD_FIRST_DATA.
  - LOAD_FIRST_DATA → LOAD_DATA, unconditionally.
  - LOAD_DATA:
    - `fifo_full[addr_q]` → FIFO_FULL_STATE.
    - Else `!pkt_valid` → LOAD_PARITY.
    - Else stay.
  - FIFO_FULL_STATE: on `!fifo_full[addr_q]` → LOAD_AFTER_FULL.
  - LOAD_AFTER_FULL:
    - `parity_done` → DECODE_ADDRESS.
    - Else `low_pkt_valid` → LOAD_PARITY.
    - Else → LOAD_DATA.
  - LOAD_PARITY → CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: `fifo_full[addr_q]` → FIFO_FULL_STATE, else → DECODE_ADDRESS.
- Abort: if `soft_rst[addr_q]` is high in any state other than DECODE_ADDRESS, the next state is DECODE_ADDRESS. This overrides every other transition.
- Timeout, per port i:
  - An 5-bit counter increments while `vld_out[i] & ~rd_en[i]`.
  - It clears to 0 on `rd_en[i]`, or when `fifo_empty[i]`.
  - When the counter equals TIMEOUT-1 and the increment condition holds, `soft_rst[i]` is registered high for one cycle and the counter clears.
  - The counter saturates; it never wraps.
- Ports are independent; simultaneous `soft_rst` on several ports is legal.

## Timing
- `rst` asserted, asynchronously:
  - State = DECODE_ADDRESS, so `detect_add`=1.
  - `addr_q`=0 and all counters = 0.
  - `wr_en`, `lfd_state`, `ld_state`, `laf_state`, `rst_int_reg`, `busy` and `soft_rst` are all 0.
  - `vld_out` follows `fifo_empty`.
- Every transition takes one clock. Header accept to the first `wr_en` is 1 cycle; `lfd_state` is high for exactly 1 cycle.
- `busy` falls in the same cycle the state enters LOAD_DATA.
- `soft_rst[i]` rises on the edge that ends the TIMEOUT-th consecutive unread cycle, i.e. cycle TIMEOUT after the first unread cycle. It lasts 1 cycle.
- Reset mid-packet returns to DECODE_ADDRESS immediately; there is no partial-packet cleanup.

## Structure
- `router_pkg` holds:
  - The state encoding: 3-bit localparams, with DECODE_ADDRESS=0.
  - `PORTS` and `TIMEOUT` defaults.
  - The invalid address constant, 3.
- Sub-module `router_sync_timer` implements one port's timeout counter and `soft_rst` register. It is instantiated PORTS times by generate.
- The FSM, `addr_q` and the output decode live in `router_fsm`.

## Test plan
- Reset, then a packet to port 1 with an empty FIFO: `detect_add`=1; 1 cycle of `lfd_state` with `wr_en`=3'b010; then `ld_state`; `pkt_valid` falls → LOAD_PARITY → CHECK_PARITY_ERROR → DECODE_ADDRESS.
- Header to port 2 while `fifo_empty[2]`=0: `busy`=1 in WAIT_TILL_EMPTY; `wr_en`=0 until empty rises; then LOAD_FIRST_DATA on the next cycle.
- `fifo_full[0]` during LOAD_DATA: FIFO_FULL_STATE with `wr_en`=0 and `busy`=1; full falls → LOAD_AFTER_FULL; `low_pkt_valid`=1 → LOAD_PARITY.
- `addr`=3 with `pkt_valid`: the FSM stays in DECODE_ADDRESS, no `wr_en` asserts, `addr_q` is unchanged.
- Port 0 FIFO non-empty and `rd_en[0]`=0:
  - After 30 cycles, `soft_rst[0]` pulses 1 cycle; if port 0 is mid-packet, the FSM goes to DECODE_ADDRESS next.
  - Variant: `rd_en` pulses at cycle 29 → no `soft_rst`.
- `rst` asserted asynchronously during LOAD_DATA: all outputs reach reset values before the next edge, with `detect_add`=1.
